// File: rtl/bsg_manycore_load_resp_router.sv
// Routes endpoint return packets to ifetch (0 cycles) or per-channel response FIFOs (1 cycle to resp_v_o).
// A full channel FIFO holds the endpoint head (returned_yumi_o=0) and raises force; optional stats via BSG_MANYCORE_LOAD_RESP_STATS_EN.
// Backpressure: resp_force_o asks the core to drain; returned_yumi_o never depends on resp_yumi_i.

module bsg_manycore_load_resp_router_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] enq_data_i,
    input  logic               deq_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wr_ptr, rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               do_enq, do_deq;

    function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o = (count == cnt_w'(els_p));
    assign v_o    = (count != '0);
    assign data_o = mem[rd_ptr];

    // a full FIFO refuses enqueue even when a dequeue happens in the same cycle
    assign do_enq = enq_i & ~full_o;
    assign do_deq = deq_i & v_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wrap_inc(wr_ptr);
            if (do_deq) rd_ptr <= wrap_inc(rd_ptr);
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq) mem[wr_ptr] <= enq_data_i;
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i) deq_i |-> v_o);
endmodule

module bsg_manycore_load_resp_router #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int num_rf_p         = 2,
    parameter int pkt_type_width_p = 2,
    parameter int buf_els_p        = 2,
    parameter int stall_limit_p    = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 returned_v_i,
    input  logic [data_width_p-1:0]              returned_data_i,
    input  logic [reg_addr_width_p-1:0]          returned_reg_id_i,
    input  logic [pkt_type_width_p-1:0]          returned_pkt_type_i,
    input  logic                                 returned_fifo_full_i,
    output logic                                 returned_yumi_o,
    output logic                                 ifetch_v_o,
    output logic [data_width_p-1:0]              ifetch_instr_o,
    output logic [num_rf_p-1:0]                  resp_v_o,
    output logic [num_rf_p*reg_addr_width_p-1:0] resp_rd_o,
    output logic [num_rf_p*data_width_p-1:0]     resp_data_o,
    output logic [num_rf_p-1:0]                  resp_force_o,
    input  logic [num_rf_p-1:0]                  resp_yumi_i,
    output logic                                 invalid_type_o,
    output logic [num_rf_p*32-1:0]               stat_count_o
);
    localparam int entry_w = reg_addr_width_p + data_width_p;
    localparam int stall_w = (stall_limit_p > 0) ? $clog2(stall_limit_p + 1) : 1;
    localparam logic [stall_w-1:0] stall_max = stall_w'(stall_limit_p);
    localparam logic stall_en = (stall_limit_p != 0);

    logic [31:0]         type_ext;
    logic [num_rf_p-1:0] rf_hit, fifo_full, fifo_v, enq;
    logic                is_ifetch, is_rf, invalid_r;

    // widen the type once so range checks work for any pkt_type_width_p
    assign type_ext  = 32'(returned_pkt_type_i);
    assign is_ifetch = returned_v_i & (type_ext == 32'd1);
    assign is_rf     = |rf_hit;

    assign returned_yumi_o = reset_n_i & returned_v_i & (is_rf ? |(rf_hit & ~fifo_full) : 1'b1);
    assign ifetch_v_o      = reset_n_i & is_ifetch;
    assign ifetch_instr_o  = returned_data_i;
    assign invalid_type_o  = reset_n_i & invalid_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            invalid_r <= 1'b0;
        else if (returned_v_i && (type_ext >= 32'(num_rf_p + 2)))
            invalid_r <= 1'b1;
    end

    for (genvar c = 0; c < num_rf_p; c++) begin : g_ch
        logic [entry_w-1:0] head;
        logic [stall_w-1:0] stall_cnt;
        logic               stall_hit;

        assign rf_hit[c] = returned_v_i & (type_ext == 32'(c + 2));
        assign enq[c]    = reset_n_i & rf_hit[c];

        bsg_manycore_load_resp_router_fifo #(
            .width_p (entry_w),
            .els_p   (buf_els_p)
        ) fifo (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .enq_i      (enq[c]),
            .enq_data_i ({returned_reg_id_i, returned_data_i}),
            .deq_i      (resp_yumi_i[c]),
            .full_o     (fifo_full[c]),
            .v_o        (fifo_v[c]),
            .data_o     (head)
        );

        assign resp_v_o[c] = reset_n_i & fifo_v[c];
        assign resp_rd_o[c*reg_addr_width_p +: reg_addr_width_p] = head[data_width_p +: reg_addr_width_p];
        assign resp_data_o[c*data_width_p +: data_width_p]       = head[data_width_p-1:0];

        always_ff @(posedge clk_i) begin
            if (!reset_n_i || !fifo_v[c] || resp_yumi_i[c])
                stall_cnt <= '0;
            else if (stall_cnt != stall_max)
                stall_cnt <= stall_cnt + 1'b1;
        end

        assign stall_hit = stall_en & (stall_cnt == stall_max);
        // force when the head is about to block the endpoint, or has waited too long
        assign resp_force_o[c] = resp_v_o[c] &
                                 (fifo_full[c] | (rf_hit[c] & returned_fifo_full_i) | stall_hit);

`ifdef BSG_MANYCORE_LOAD_RESP_STATS_EN
        logic [31:0] stat_cnt;
        always_ff @(posedge clk_i) begin
            if (!reset_n_i)
                stat_cnt <= '0;
            else if (resp_yumi_i[c] && fifo_v[c] && (stat_cnt != 32'hFFFF_FFFF))
                stat_cnt <= stat_cnt + 32'd1;
        end
        assign stat_count_o[c*32 +: 32] = reset_n_i ? stat_cnt : 32'd0;
`else
        assign stat_count_o[c*32 +: 32] = 32'd0;
`endif
    end
endmodule
